// File: rtl/memory_multi_port.sv
// Shared dual-port RAM serving NUM_READ_PORTS/NUM_WRITE_PORTS PE channels plus a host port,
// with host-priority round-robin arbitration per side and buffered per-port read results.
module memory_multi_port #(
   parameter int DEPTH           = 1024,
   parameter int WORD_WIDTH      = 32,
   parameter int NUM_READ_PORTS  = 2,
   parameter int NUM_WRITE_PORTS = 2
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  enable,
   input  logic                                  host_read_req,
   input  logic [WORD_WIDTH-1:0]                 host_read_index,
   output logic [WORD_WIDTH-1:0]                 host_read_data,
   output logic                                  host_read_ack,
   input  logic                                  host_write_req,
   input  logic [WORD_WIDTH-1:0]                 host_write_index,
   input  logic [WORD_WIDTH-1:0]                 host_write_data,
   output logic                                  host_write_ack,
   input  logic [NUM_READ_PORTS-1:0]             read_index_valid,
   output logic [NUM_READ_PORTS-1:0]             read_index_ready,
   input  logic [NUM_READ_PORTS*WORD_WIDTH-1:0]  read_index_data,
   output logic [NUM_READ_PORTS-1:0]             read_data_valid,
   input  logic [NUM_READ_PORTS-1:0]             read_data_ready,
   output logic [NUM_READ_PORTS*WORD_WIDTH-1:0]  read_data_data,
   input  logic [NUM_WRITE_PORTS-1:0]            write_index_valid,
   output logic [NUM_WRITE_PORTS-1:0]            write_index_ready,
   input  logic [NUM_WRITE_PORTS*WORD_WIDTH-1:0] write_index_data,
   input  logic [NUM_WRITE_PORTS-1:0]            write_data_valid,
   output logic [NUM_WRITE_PORTS-1:0]            write_data_ready,
   input  logic [NUM_WRITE_PORTS*WORD_WIDTH-1:0] write_data_data,
   output logic                                  quiescent
);
   localparam int AW  = $clog2(DEPTH);
   localparam int RPW = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1;
   localparam int WPW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

   logic [WORD_WIDTH-1:0] mem [DEPTH];
   logic [WORD_WIDTH-1:0] ram_q_reg;
   logic                  ram_rd_en, ram_wr_en;
   logic [AW-1:0]         ram_rd_addr, ram_wr_addr;
   logic [WORD_WIDTH-1:0] ram_wr_data;

   logic [AW-1:0]         rd_addr_arr [NUM_READ_PORTS];
   logic [AW-1:0]         wr_addr_arr [NUM_WRITE_PORTS];
   logic [WORD_WIDTH-1:0] wr_data_arr [NUM_WRITE_PORTS];
   logic [WORD_WIDTH-1:0] slot_data_reg [NUM_READ_PORTS];
   logic [NUM_READ_PORTS-1:0]  slot_valid_reg, slot_fill, rd_eligible;
   logic [NUM_WRITE_PORTS-1:0] wr_eligible;

   logic [RPW-1:0] rd_ptr_reg, rd_ptr_next, pe_rd_port, inflight_port_reg;
   logic [WPW-1:0] wr_ptr_reg, wr_ptr_next, pe_wr_port;
   logic           host_rd_grant, pe_rd_grant, host_wr_grant, pe_wr_grant;
   logic           inflight_valid_reg, inflight_host_reg;
   logic           quiescent_reg, quiescent_next;
   int             rd_idx, wr_idx;
   logic           unused_index_bits;

   // Only the low AW index bits address the RAM; the rest wrap away.
   assign unused_index_bits = ^{host_read_index, host_write_index, read_index_data, write_index_data};

   // Read-first RAM: the read register samples the old word on a same-address write.
   always_ff @(posedge clock) begin
      if (ram_wr_en)
         mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_en)
         ram_q_reg <= mem[ram_rd_addr];
   end

   generate
      for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
         assign rd_addr_arr[gi] = read_index_data[gi*WORD_WIDTH +: AW];
         assign slot_fill[gi]   = inflight_valid_reg && !inflight_host_reg &&
                                  (inflight_port_reg == RPW'(gi));
         assign rd_eligible[gi] = read_index_valid[gi] && !slot_valid_reg[gi] && !slot_fill[gi];
         assign read_data_data[gi*WORD_WIDTH +: WORD_WIDTH] = slot_data_reg[gi];
      end
      for (genvar gi = 0; gi < NUM_WRITE_PORTS; gi++) begin : g_wr
         assign wr_addr_arr[gi] = write_index_data[gi*WORD_WIDTH +: AW];
         assign wr_data_arr[gi] = write_data_data[gi*WORD_WIDTH +: WORD_WIDTH];
         assign wr_eligible[gi] = write_index_valid[gi] && write_data_valid[gi];
      end
   endgenerate

   always_comb begin
      host_rd_grant    = 1'b0;
      pe_rd_grant      = 1'b0;
      pe_rd_port       = '0;
      rd_idx           = 0;
      read_index_ready = '0;
      rd_ptr_next      = rd_ptr_reg;
      if (enable) begin
         if (host_read_req && !host_read_ack) begin
            host_rd_grant = 1'b1;
         end else begin
            for (int i = 0; i < NUM_READ_PORTS; i++) begin
               rd_idx = int'(rd_ptr_reg) + i;
               if (rd_idx >= NUM_READ_PORTS)
                  rd_idx = rd_idx - NUM_READ_PORTS;
               if (!pe_rd_grant && rd_eligible[RPW'(rd_idx)]) begin
                  pe_rd_grant = 1'b1;
                  pe_rd_port  = RPW'(rd_idx);
               end
            end
            if (pe_rd_grant) begin
               read_index_ready[pe_rd_port] = 1'b1;
               rd_ptr_next = (pe_rd_port == RPW'(NUM_READ_PORTS-1)) ? '0 : pe_rd_port + 1'b1;
            end
         end
      end
   end

   always_comb begin
      host_wr_grant     = 1'b0;
      pe_wr_grant       = 1'b0;
      pe_wr_port        = '0;
      wr_idx            = 0;
      write_index_ready = '0;
      wr_ptr_next       = wr_ptr_reg;
      if (enable) begin
         if (host_write_req) begin
            host_wr_grant = 1'b1;
         end else begin
            for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
               wr_idx = int'(wr_ptr_reg) + i;
               if (wr_idx >= NUM_WRITE_PORTS)
                  wr_idx = wr_idx - NUM_WRITE_PORTS;
               if (!pe_wr_grant && wr_eligible[WPW'(wr_idx)]) begin
                  pe_wr_grant = 1'b1;
                  pe_wr_port  = WPW'(wr_idx);
               end
            end
            if (pe_wr_grant) begin
               write_index_ready[pe_wr_port] = 1'b1;
               wr_ptr_next = (pe_wr_port == WPW'(NUM_WRITE_PORTS-1)) ? '0 : pe_wr_port + 1'b1;
            end
         end
      end
   end

   assign write_data_ready = write_index_ready;
   assign host_write_ack   = host_wr_grant;
   assign ram_rd_en        = host_rd_grant || pe_rd_grant;
   assign ram_rd_addr      = host_rd_grant ? host_read_index[AW-1:0] : rd_addr_arr[pe_rd_port];
   assign ram_wr_en        = host_wr_grant || pe_wr_grant;
   assign ram_wr_addr      = host_wr_grant ? host_write_index[AW-1:0] : wr_addr_arr[pe_wr_port];
   assign ram_wr_data      = host_wr_grant ? host_write_data : wr_data_arr[pe_wr_port];

   assign host_read_ack   = inflight_valid_reg && inflight_host_reg;
   assign host_read_data  = ram_q_reg;
   assign read_data_valid = slot_valid_reg;
   assign quiescent       = quiescent_reg;
   assign quiescent_next  = !(|read_index_valid) && !(|write_index_valid) && !(|write_data_valid) &&
                            !(|slot_valid_reg) && !inflight_valid_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_reg         <= '0;
         wr_ptr_reg         <= '0;
         inflight_valid_reg <= 1'b0;
         inflight_host_reg  <= 1'b0;
         inflight_port_reg  <= '0;
         quiescent_reg      <= 1'b0;
         slot_valid_reg     <= '0;
      end else if (enable) begin
         rd_ptr_reg         <= rd_ptr_next;
         wr_ptr_reg         <= wr_ptr_next;
         inflight_valid_reg <= ram_rd_en;
         inflight_host_reg  <= host_rd_grant;
         inflight_port_reg  <= pe_rd_port;
         quiescent_reg      <= quiescent_next;
         for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (slot_fill[p])
               slot_valid_reg[p] <= 1'b1;
            else if (read_data_ready[p])
               slot_valid_reg[p] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         if (enable && slot_fill[p])
            slot_data_reg[p] <= ram_q_reg;
      end
   end
endmodule

// File: tb/tb_memory_multi_port.sv
// Directed bench for memory_multi_port: host access, wrap, round-robin, back-pressure,
// write arbitration, read-first collisions, enable hold and async reset.
module tb_memory_multi_port;
   localparam int DEPTH = 16;
   localparam int W     = 32;
   localparam int NR    = 2;
   localparam int NW    = 2;

   logic clock, reset, enable;
   logic host_read_req, host_read_ack, host_write_req, host_write_ack, quiescent;
   logic [W-1:0] host_read_index, host_read_data, host_write_index, host_write_data;
   logic [NR-1:0] read_index_valid, read_index_ready, read_data_valid, read_data_ready;
   logic [NR*W-1:0] read_index_data, read_data_data;
   logic [NW-1:0] write_index_valid, write_index_ready, write_data_valid, write_data_ready;
   logic [NW*W-1:0] write_index_data, write_data_data;
   int checks = 0;
   int errors = 0;

   memory_multi_port #(.DEPTH(DEPTH), .WORD_WIDTH(W), .NUM_READ_PORTS(NR), .NUM_WRITE_PORTS(NW)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .host_read_req(host_read_req), .host_read_index(host_read_index),
      .host_read_data(host_read_data), .host_read_ack(host_read_ack),
      .host_write_req(host_write_req), .host_write_index(host_write_index),
      .host_write_data(host_write_data), .host_write_ack(host_write_ack),
      .read_index_valid(read_index_valid), .read_index_ready(read_index_ready),
      .read_index_data(read_index_data), .read_data_valid(read_data_valid),
      .read_data_ready(read_data_ready), .read_data_data(read_data_data),
      .write_index_valid(write_index_valid), .write_index_ready(write_index_ready),
      .write_index_data(write_index_data), .write_data_valid(write_data_valid),
      .write_data_ready(write_data_ready), .write_data_data(write_data_data),
      .quiescent(quiescent)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rd_step(input string tag, input logic [NR-1:0] exp_rir, input logic [NR-1:0] exp_rdv);
      #1;
      check({tag, " read_index_ready"}, 32'(read_index_ready), 32'(exp_rir));
      check({tag, " read_data_valid"}, 32'(read_data_valid), 32'(exp_rdv));
   endtask

   task automatic host_write(input logic [W-1:0] idx, input logic [W-1:0] data);
      host_write_req   = 1'b1;
      host_write_index = idx;
      host_write_data  = data;
      #1 check("host_write_ack", 32'(host_write_ack), 32'd1);
      $display("host write index %0d data 0x%0h", idx, data);
      tick();
      host_write_req = 1'b0;
   endtask

   task automatic host_read(input logic [W-1:0] idx, input logic [W-1:0] exp, input string tag);
      host_read_req   = 1'b1;
      host_read_index = idx;
      #1 check({tag, " ack in grant cycle"}, 32'(host_read_ack), 32'd0);
      tick();
      check({tag, " ack"}, 32'(host_read_ack), 32'd1);
      check({tag, " data"}, host_read_data, exp);
      $display("host read index %0d data 0x%0h", idx, host_read_data);
      tick();
      host_read_req = 1'b0;
      check({tag, " ack single cycle"}, 32'(host_read_ack), 32'd0);
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1;
      host_read_req = 1'b0; host_read_index = '0;
      host_write_req = 1'b0; host_write_index = '0; host_write_data = '0;
      read_index_valid = '0; read_index_data = '0; read_data_ready = '1;
      write_index_valid = '0; write_index_data = '0; write_data_valid = '0; write_data_data = '0;
      tick(); tick();
      check("reset read_data_valid", 32'(read_data_valid), 32'd0);
      check("reset host_read_ack", 32'(host_read_ack), 32'd0);
      check("reset quiescent", 32'(quiescent), 32'd0);
      reset = 1'b1;
      tick(); tick();
      check("idle quiescent", 32'(quiescent), 32'd1);

      // Host access and address wrap
      host_write(32'd5, 32'hA5);
      host_read(32'd5, 32'hA5, "host rd 5");
      host_read(32'd5 + DEPTH, 32'hA5, "host rd wrap");
      host_write(32'd8, 32'h1008);
      host_write(32'd9, 32'h1009);
      host_write(32'd10, 32'h100A);
      host_write(32'd11, 32'h100B);
      host_write(32'd7, 32'h11);
      host_write(32'd14, 32'h44);

      // Round robin with both ports always requesting and ready
      read_index_valid = 2'b11;
      read_index_data  = {32'd9, 32'd8};
      read_data_ready  = 2'b11;
      rd_step("rr c0", 2'b01, 2'b00); tick();
      read_index_data[31:0] = 32'd10;
      rd_step("rr c1", 2'b10, 2'b00); tick();
      read_index_data[63:32] = 32'd11;
      rd_step("rr c2", 2'b00, 2'b01);
      check("rr c2 data0", read_data_data[31:0], 32'h1008); tick();
      rd_step("rr c3", 2'b01, 2'b10);
      check("rr c3 data1", read_data_data[63:32], 32'h1009); tick();
      rd_step("rr c4", 2'b10, 2'b00); tick();
      rd_step("rr c5", 2'b00, 2'b01);
      check("rr c5 data0", read_data_data[31:0], 32'h100A); tick();
      read_data_ready = 2'b10;
      rd_step("rr c6", 2'b01, 2'b10);
      check("rr c6 data1", read_data_data[63:32], 32'h100B); tick();

      // Port 0 back-pressured: port 1 takes every grant
      rd_step("bp c7", 2'b10, 2'b00); tick();
      rd_step("bp c8", 2'b00, 2'b01);
      check("bp c8 data0", read_data_data[31:0], 32'h100A); tick();
      rd_step("bp c9", 2'b00, 2'b11);
      check("bp c9 data1", read_data_data[63:32], 32'h100B); tick();
      rd_step("bp c10", 2'b10, 2'b01); tick();
      rd_step("bp c11", 2'b00, 2'b01); tick();
      rd_step("bp c12", 2'b00, 2'b11);
      check("bp c12 data0 stable", read_data_data[31:0], 32'h100A); tick();
      read_data_ready = 2'b11;
      rd_step("bp c13", 2'b10, 2'b01); tick();
      rd_step("readmit c14", 2'b01, 2'b00); tick();
      read_index_valid = 2'b00;
      rd_step("drain c15", 2'b00, 2'b10); tick();
      rd_step("drain c16", 2'b00, 2'b01); tick();
      rd_step("drain c17", 2'b00, 2'b00);

      // Write arbitration: host beats port 1, port 0 lacks data
      host_write_req    = 1'b1;
      host_write_index  = 32'd12;
      host_write_data   = 32'h22C;
      write_index_valid = 2'b11;
      write_data_valid  = 2'b10;
      write_index_data  = {32'd13, 32'd14};
      write_data_data   = {32'h33D, 32'hDEAD};
      #1;
      check("wr host ack", 32'(host_write_ack), 32'd1);
      check("wr host cycle index_ready", 32'(write_index_ready), 32'd0);
      check("wr host cycle data_ready", 32'(write_data_ready), 32'd0);
      tick();
      host_write_req = 1'b0;
      #1;
      check("wr port1 index_ready", 32'(write_index_ready), 32'b10);
      check("wr port1 data_ready", 32'(write_data_ready), 32'b10);
      tick();
      write_index_valid = 2'b01;
      write_data_valid  = 2'b00;
      #1;
      check("wr port0 no data index_ready", 32'(write_index_ready), 32'd0);
      check("wr port0 no data data_ready", 32'(write_data_ready), 32'd0);
      tick();
      write_index_valid = 2'b00;
      host_read(32'd12, 32'h22C, "host wr 12");
      host_read(32'd13, 32'h33D, "pe wr 13");
      host_read(32'd14, 32'h44, "pe wr0 not popped");

      // Same-cycle read/write to index 7 is read-first
      write_index_valid = 2'b01;
      write_data_valid  = 2'b01;
      write_index_data[31:0] = 32'd7;
      write_data_data[31:0]  = 32'h22;
      read_index_valid = 2'b01;
      read_index_data[31:0] = 32'd7;
      #1;
      check("rw read grant", 32'(read_index_ready), 32'b01);
      check("rw write grant", 32'(write_index_ready), 32'b01);
      tick();
      write_index_valid = 2'b00;
      write_data_valid  = 2'b00;
      read_index_valid  = 2'b10;
      read_index_data[63:32] = 32'd7;
      rd_step("rw c1", 2'b10, 2'b00); tick();
      read_index_valid = 2'b00;
      read_data_ready  = 2'b01;
      rd_step("rw c2", 2'b00, 2'b01);
      check("rw old data", read_data_data[31:0], 32'h11); tick();
      rd_step("rw c3", 2'b00, 2'b10);
      check("rw new data", read_data_data[63:32], 32'h22);

      // enable=0 freezes everything
      enable = 1'b0;
      read_index_valid  = 2'b11;
      read_index_data   = {32'd9, 32'd8};
      read_data_ready   = 2'b11;
      write_index_valid = 2'b11;
      write_data_valid  = 2'b11;
      host_write_req    = 1'b1;
      host_write_index  = 32'd12;
      host_write_data   = 32'hBAD;
      host_read_req     = 1'b1;
      host_read_index   = 32'd5;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("hold read_index_ready", 32'(read_index_ready), 32'd0);
         check("hold write_index_ready", 32'(write_index_ready), 32'd0);
         check("hold host_write_ack", 32'(host_write_ack), 32'd0);
         check("hold host_read_ack", 32'(host_read_ack), 32'd0);
         check("hold read_data_valid", 32'(read_data_valid), 32'b10);
         check("hold data1", read_data_data[63:32], 32'h22);
         tick();
      end
      enable = 1'b1;
      read_index_valid  = 2'b00;
      write_index_valid = 2'b00;
      write_data_valid  = 2'b00;
      host_write_req    = 1'b0;
      host_read_req     = 1'b0;
      #1 check("resume read_data_valid", 32'(read_data_valid), 32'b10);
      tick();
      host_read(32'd12, 32'h22C, "write blocked by enable");

      // Async reset with a result pending and a read in flight
      read_index_valid = 2'b11;
      read_index_data  = {32'd9, 32'd8};
      read_data_ready  = 2'b00;
      rd_step("rst c0", 2'b01, 2'b00); tick();
      rd_step("rst c1", 2'b10, 2'b00); tick();
      rd_step("rst c2", 2'b00, 2'b01);
      check("rst c2 data0", read_data_data[31:0], 32'h1008);
      #2 reset = 1'b0;
      #1;
      check("async reset read_data_valid", 32'(read_data_valid), 32'd0);
      check("async reset quiescent", 32'(quiescent), 32'd0);
      check("async reset host_read_ack", 32'(host_read_ack), 32'd0);
      read_index_valid = 2'b00;
      read_data_ready  = 2'b11;
      tick();
      reset = 1'b1;
      tick();
      check("in-flight read discarded", 32'(read_data_valid), 32'd0);
      tick();
      check("post-reset quiescent", 32'(quiescent), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
